// File: rtl/neuron_mac_if.sv
// Handshake and data bundle between the index-counter side and one neuron MAC.
// The master drives terms and start; the slave (the MAC) returns status and the activation.
interface neuron_mac_if #(
    parameter int DATA_W = 16
);
    logic                     start;
    logic signed [DATA_W-1:0] bias;
    logic                     in_valid;
    logic [31:0]              in_idx;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] w_in;
    logic                     busy;
    logic signed [DATA_W-1:0] y_out;
    logic                     out_valid;
    logic                     sat;
    logic                     idx_err;

    modport master (
        output start, bias, in_valid, in_idx, x_in, w_in,
        input  busy, y_out, out_valid, sat, idx_err
    );

    modport slave (
        input  start, bias, in_valid, in_idx, x_in, w_in,
        output busy, y_out, out_valid, sat, idx_err
    );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron dot-product engine: bias + sum(x*w), arithmetic shift, saturation and ReLU.
// Terms are taken strictly in index order; repeats are ignored, forward skips abort the neuron.
module neuron_mac #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ACC_W    = 48,
    parameter int N_INPUTS = 820
) (
    input  logic          clk,
    input  logic          rstn,
    neuron_mac_if.slave   bus
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [31:0] LAST_IDX = 32'(N_INPUTS - 1);
    localparam logic signed [DATA_W-1:0] MAX_Y   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  MAX_POS = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        ACT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]              exp_idx_q, exp_idx_d;
    logic                     busy_q, busy_d;
    logic                     idx_err_q, idx_err_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q, sat_d;
    logic signed [DATA_W-1:0] y_q, y_d;

    logic                     vld_p0_q, vld_p0_d;
    logic signed [DATA_W-1:0] x_p0_q, x_p0_d;
    logic signed [DATA_W-1:0] w_p0_q, w_p0_d;
    logic                     vld_p1_q, vld_p1_d;
    logic signed [PROD_W-1:0] prod_p1_q, prod_p1_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    logic                     accept;
    logic                     skip_err;
    logic [DATA_W:0]          act_res;

    function automatic logic signed [PROD_W-1:0] mul_full(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PROD_W-1:0] ae;
        logic signed [PROD_W-1:0] be;
        ae = {{DATA_W{a[DATA_W-1]}}, a};
        be = {{DATA_W{b[DATA_W-1]}}, b};
        return ae * be;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [PROD_W-1:0] p
    );
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Bias enters the accumulator at product scale (2*FRAC_W fraction bits).
    function automatic logic signed [ACC_W-1:0] bias_init(
        input logic signed [DATA_W-1:0] b
    );
        return {{(ACC_W-DATA_W-FRAC_W){b[DATA_W-1]}}, b, {FRAC_W{1'b0}}};
    endfunction

    // Returns {sat, y}: clip on positive overflow, ReLU forces negatives to zero unsaturated.
    function automatic logic [DATA_W:0] act_relu_sat(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] r;
        r = a >>> FRAC_W;
        if (r[ACC_W-1]) begin
            return '0;
        end else if (r > MAX_POS) begin
            return {1'b1, MAX_Y};
        end else begin
            return {1'b0, r[DATA_W-1:0]};
        end
    endfunction

    assign accept   = (state_q == ACCUM) && bus.in_valid && (bus.in_idx == exp_idx_q);
    assign skip_err = (state_q == ACCUM) && bus.in_valid && (bus.in_idx > exp_idx_q);
    assign act_res  = act_relu_sat(acc_q);

    always_comb begin
        state_d     = state_q;
        exp_idx_d   = exp_idx_q;
        busy_d      = busy_q;
        idx_err_d   = idx_err_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        y_d         = y_q;

        // stage p0: capture accepted operands
        vld_p0_d = accept;
        x_p0_d   = accept ? bus.x_in : x_p0_q;
        w_p0_d   = accept ? bus.w_in : w_p0_q;

        // stage p1: full-precision product
        vld_p1_d  = vld_p0_q;
        prod_p1_d = vld_p0_q ? mul_full(x_p0_q, w_p0_q) : prod_p1_q;

        // stage p2: accumulate, wrapping modulo 2^ACC_W
        acc_d = vld_p1_q ? (acc_q + sext_prod(prod_p1_q)) : acc_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ACCUM;
                    busy_d    = 1'b1;
                    acc_d     = bias_init(bus.bias);
                    exp_idx_d = '0;
                    idx_err_d = 1'b0;
                end
            end
            ACCUM: begin
                if (skip_err) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    idx_err_d = 1'b1;
                    vld_p0_d  = 1'b0;
                    vld_p1_d  = 1'b0;
                end else if (accept) begin
                    exp_idx_d = exp_idx_q + 32'd1;
                    if (exp_idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave once the last product is being added this cycle.
                if (vld_p1_q && !vld_p0_q) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                sat_d       = act_res[DATA_W];
                y_d         = act_res[DATA_W-1:0];
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            exp_idx_q   <= '0;
            busy_q      <= 1'b0;
            idx_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            y_q         <= '0;
            vld_p0_q    <= 1'b0;
            x_p0_q      <= '0;
            w_p0_q      <= '0;
            vld_p1_q    <= 1'b0;
            prod_p1_q   <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            exp_idx_q   <= exp_idx_d;
            busy_q      <= busy_d;
            idx_err_q   <= idx_err_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            y_q         <= y_d;
            vld_p0_q    <= vld_p0_d;
            x_p0_q      <= x_p0_d;
            w_p0_q      <= w_p0_d;
            vld_p1_q    <= vld_p1_d;
            prod_p1_q   <= prod_p1_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.idx_err   = idx_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;
    assign bus.y_out     = y_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed bench for neuron_mac with N_INPUTS=4, scored against
// an integer model of bias + dot product, floor shift, clip and ReLU.
module tb_neuron_mac;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int N      = 4;

    logic clk;
    logic rstn;

    neuron_mac_if #(.DATA_W(DATA_W)) bus ();

    neuron_mac #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .ACC_W    (48),
        .N_INPUTS (N)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks;
    int errors;
    int cyc;
    int ov_cnt;
    int ov_cyc;
    int t_last;
    logic signed [DATA_W-1:0] y_cap;
    logic                     sat_cap;
    int xs[N];
    int ws[N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ov_cnt  = 0;
        ov_cyc  = 0;
        y_cap   = '0;
        sat_cap = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.out_valid) begin
            ov_cnt  <= ov_cnt + 1;
            ov_cyc  <= cyc;
            y_cap   <= bus.y_out;
            sat_cap <= bus.sat;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input int b, output longint y, output longint s);
        longint sum;
        longint r;
        sum = longint'(b) * (longint'(1) << FRAC_W);
        for (int i = 0; i < N; i++) sum += longint'(xs[i]) * longint'(ws[i]);
        r = sum >>> FRAC_W;
        if (r > 32767) begin
            y = 32767; s = 1;
        end else if (r < 0) begin
            y = 0; s = 0;
        end else begin
            y = r; s = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    task automatic start_neuron(input int b);
        bus.start = 1'b1;
        bus.bias  = 16'(b);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic drive_term(input int idx, input int x, input int w);
        bus.in_valid = 1'b1;
        bus.in_idx   = 32'(idx);
        bus.x_in     = 16'(x);
        bus.w_in     = 16'(w);
    endtask

    task automatic send_terms(input int upto, input int gap_max, input bit dup);
        for (int i = 0; i < upto; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    bus.in_valid = 1'b0;
                    tick();
                end
            end
            drive_term(i, xs[i], ws[i]);
            if (i == N - 1) t_last = cyc + 1;
            tick();
            if (dup && i > 0 && i < N - 1 && $urandom_range(1, 0) == 1) begin
                drive_term(i - 1, rnd16(), rnd16());
                tick();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_case(input string tag, input int b, input int gap_max,
                            input bit hold, input bit dup);
        longint ey;
        longint es;
        int ov0;
        model(b, ey, es);
        start_neuron(b);
        chk({tag, "_busy_hi"}, longint'(bus.busy), 1);
        chk({tag, "_err_clr"}, longint'(bus.idx_err), 0);
        ov0 = ov_cnt;
        send_terms(N, gap_max, dup);
        if (hold) begin
            repeat (10) begin
                drive_term(N - 1, rnd16(), rnd16());
                tick();
            end
            bus.in_valid = 1'b0;
        end
        repeat (8) tick();
        chk({tag, "_pulses"}, longint'(ov_cnt - ov0), 1);
        chk({tag, "_y"}, longint'(y_cap), ey);
        chk({tag, "_sat"}, longint'(sat_cap), es);
        chk({tag, "_lat"}, longint'(ov_cyc - t_last), 3);
        chk({tag, "_busy_lo"}, longint'(bus.busy), 0);
        chk({tag, "_err"}, longint'(bus.idx_err), 0);
    endtask

    task automatic load_case1();
        xs = '{256, 256, 256, 256};
        ws = '{256, 512, -256, 256};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ov0;
        checks       = 0;
        errors       = 0;
        t_last       = 0;
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.bias     = '0;
        bus.in_valid = 1'b0;
        bus.in_idx   = '0;
        bus.x_in     = '0;
        bus.w_in     = '0;
        repeat (2) tick();
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_ov", longint'(bus.out_valid), 0);
        chk("rst_y", longint'(bus.y_out), 0);
        chk("rst_sat", longint'(bus.sat), 0);
        chk("rst_err", longint'(bus.idx_err), 0);
        rstn = 1'b1;
        tick();

        load_case1();
        run_case("c1", 0, 0, 0, 0);

        xs = '{256, 256, 256, 256};
        ws = '{-256, -256, -256, -256};
        run_case("c2", 128, 0, 0, 0);

        xs = '{32767, 32767, 32767, 32767};
        ws = '{32767, 32767, 32767, 32767};
        run_case("c3", 0, 0, 0, 0);

        load_case1();
        run_case("c4_hold", 0, 0, 1, 0);
        run_case("c4_gaps", 0, 3, 1, 0);

        load_case1();
        start_neuron(0);
        ov0 = ov_cnt;
        send_terms(2, 0, 0);
        drive_term(3, 256, 256);
        tick();
        bus.in_valid = 1'b0;
        chk("c5_err_set", longint'(bus.idx_err), 1);
        chk("c5_busy", longint'(bus.busy), 0);
        repeat (8) tick();
        chk("c5_no_ov", longint'(ov_cnt - ov0), 0);
        chk("c5_err_sticky", longint'(bus.idx_err), 1);
        run_case("c5_retry", 0, 0, 0, 0);

        start_neuron(0);
        ov0 = ov_cnt;
        send_terms(2, 0, 0);
        #3 rstn = 1'b0;
        #1;
        chk("c6_busy", longint'(bus.busy), 0);
        chk("c6_y", longint'(bus.y_out), 0);
        chk("c6_ov", longint'(bus.out_valid), 0);
        chk("c6_sat", longint'(bus.sat), 0);
        tick();
        rstn = 1'b1;
        repeat (6) tick();
        chk("c6_no_ov", longint'(ov_cnt - ov0), 0);
        load_case1();
        run_case("c6_retry", 0, 0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            int b;
            for (int i = 0; i < N; i++) begin
                if (k % 2 == 0) begin
                    xs[i] = rnd16();
                    ws[i] = rnd16();
                end else begin
                    xs[i] = int'($urandom_range(2047, 0)) - 1024;
                    ws[i] = int'($urandom_range(2047, 0)) - 1024;
                end
            end
            b = (k % 3 == 0) ? rnd16() : int'($urandom_range(4095, 0)) - 2048;
            run_case($sformatf("rnd%0d", k), b, int'($urandom_range(2, 0)),
                     1'($urandom_range(1, 0)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
